// File: rtl/grf_wb_scheduler.sv
// Write-port scheduler for the GRF: merges in-order W-stage writes with buffered
// long-latency results and tracks per-register pending state for decode stalls.
module grf_wb_scheduler #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_valid,
  input  logic [4:0]  p_addr,
  input  logic [31:0] p_data,
  input  logic [31:0] p_pc,
  output logic        p_stall,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  output logic        iss_ready,
  input  logic        l_valid,
  input  logic [4:0]  l_addr,
  input  logic [31:0] l_data,
  input  logic [31:0] l_pc,
  output logic        l_ready,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        rs_busy,
  output logic        rt_busy,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] wr_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    fifo_addr_r [DEPTH];
  logic [31:0]   fifo_data_r [DEPTH];
  logic [31:0]   fifo_pc_r   [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r, outstanding_r;
  logic [SW-1:0] starve_r;
  logic [31:0]   pending_r, pending_nxt_s;
  logic          fifo_empty_s, pipe_sel_s, pop_s, push_s, issue_s;
  logic [4:0]    head_addr_s;

  // Handshakes, write-source selection and starvation relief
  always_comb begin
    fifo_empty_s = (count_r == CW'(0));
    head_addr_s  = fifo_addr_r[rd_ptr_r];
    p_stall      = !fifo_empty_s && (starve_r >= SW'(STARVE_MAX));
    pipe_sel_s   = p_valid && !p_stall;
    pop_s        = !fifo_empty_s && !pipe_sel_s;
    l_ready      = (count_r != CW'(DEPTH));
    push_s       = l_valid && l_ready;
    iss_ready    = (outstanding_r < CW'(DEPTH)) &&
                   !((iss_addr != 5'd0) && pending_r[iss_addr]);
    issue_s      = iss_valid && iss_ready;
    rs_busy      = pending_r[rs_addr];
    rt_busy      = pending_r[rt_addr];
  end

  // Pending scoreboard update; a refused same-register issue never collides with the clear
  always_comb begin
    pending_nxt_s = pending_r;
    if (pop_s) begin
      pending_nxt_s[head_addr_s] = 1'b0;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (issue_s && (iss_addr != 5'd0)) begin
      pending_nxt_s[iss_addr] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    pending_nxt_s[0] = 1'b0;
  end

  // FIFO payload storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= l_addr;
      fifo_data_r[wr_ptr_r] <= l_data;
      fifo_pc_r[wr_ptr_r]   <= l_pc;
    end
  end

  // FIFO pointers, occupancy, outstanding count, scoreboard and starvation counter
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r      <= AW'(0);
      rd_ptr_r      <= AW'(0);
      count_r       <= CW'(0);
      outstanding_r <= CW'(0);
      starve_r      <= SW'(0);
      pending_r     <= 32'd0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      case ({issue_s, pop_s})
        2'b10:   outstanding_r <= outstanding_r + CW'(1);
        2'b01:   outstanding_r <= outstanding_r - CW'(1);
        default: outstanding_r <= outstanding_r;
      endcase
      if (pop_s || fifo_empty_s) starve_r <= SW'(0);
      else                       starve_r <= starve_r + SW'(1);
      pending_r <= pending_nxt_s;
    end
  end

  // Registered GRF write port; writes to $0 are dropped but still consume the slot
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= 5'd0;
      wr_data <= 32'd0;
      wr_pc   <= 32'd0;
    end else if (pipe_sel_s) begin
      wr_en   <= (p_addr != 5'd0);
      wr_addr <= p_addr;
      wr_data <= p_data;
      wr_pc   <= p_pc;
    end else if (pop_s) begin
      wr_en   <= (head_addr_s != 5'd0);
      wr_addr <= head_addr_s;
      wr_data <= fifo_data_r[rd_ptr_r];
      wr_pc   <= fifo_pc_r[rd_ptr_r];
    end else begin
      wr_en   <= 1'b0;
    end
  end
endmodule
